// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the instruction-fetch
// port and the load/store port. Data accesses win unless the fetch has starved too long.
module mem_arbiter #(
  parameter int WAIT_STATES  = 0,
  parameter int MAX_D_STREAK = 4,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        o_state
);

  // Handshake: a requester holds req and its payload until it sees gnt in the
  // same cycle; dropping req earlier withdraws it. Each grant yields exactly
  // one rvalid pulse 2+WAIT_STATES cycles later; there is no backpressure on rvalid.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_wait_cnt;
  logic [3:0]  r_streak;
  logic        r_owner_d;
  logic        r_we;
  logic        w_arb;
  logic        w_exhausted;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_grant;

  always_comb begin
    w_arb       = (r_state != ST_ACCESS);
    w_exhausted = (r_streak == STREAK_MAX) && i_req;
    w_grant_d   = w_arb && d_req && !w_exhausted;
    w_grant_i   = w_arb && i_req && !w_grant_d;
    w_grant     = w_grant_d || w_grant_i;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_wait_cnt == 3'd0) w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = w_grant ? ST_ACCESS : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The memory-side registers double as the transaction latch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= 3'd0;
      r_streak   <= 4'd0;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (w_grant) begin
        r_wait_cnt <= WAIT_INIT;
        r_owner_d  <= w_grant_d;
        r_we       <= w_grant_d && d_we;
        mem_addr   <= w_grant_d ? d_addr : i_addr;
        if (w_grant_d) mem_wdata <= d_wdata;
      end else if (r_state == ST_ACCESS && r_wait_cnt != 3'd0) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      mem_en <= (w_state_nxt == ST_ACCESS);
      mem_we <= (w_state_nxt == ST_ACCESS) && (w_grant ? (w_grant_d && d_we) : r_we);
      if (!i_req || w_grant_i) begin
        r_streak <= 4'd0;
      end else if (w_grant_d && r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  always_comb begin
    i_gnt    = w_grant_i && !RST;
    d_gnt    = w_grant_d && !RST;
    i_rvalid = (r_state == ST_RESP) && !r_owner_d;
    d_rvalid = (r_state == ST_RESP) && r_owner_d;
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = (d_rvalid && !r_we) ? mem_rdata : '0;
    o_state  = r_state;
  end

endmodule
